// File: rtl/scratchmem_arb2_fta.sv
// rtl/scratchmem_arb2_fta.sv - two-port round-robin arbiter onto one FTA scratchpad; optional tid check via SCRATCH_ARB_TIDCHK_EN
package fta_bus_pkg;

    localparam logic [2:0] CLASSIC = 3'd0;
    localparam logic [2:0] FIXED   = 3'd1;
    localparam logic [2:0] INCR    = 3'd2;
    localparam logic [2:0] ERC     = 3'd7;

    localparam logic [1:0] OKAY    = 2'd0;
    localparam logic [1:0] DECERR  = 2'd1;
    localparam logic [1:0] SLVERR  = 2'd2;

    typedef struct packed {
        logic [3:0]   pri;
        logic [7:0]   tid;
        logic [7:0]   asid;
        logic         cyc;
        logic         stb;
        logic         we;
        logic [2:0]   cti;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic         ctag;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic [3:0]   pri;
        logic [7:0]   tid;
        logic [7:0]   asid;
        logic         ack;
        logic         stall;
        logic         next;
        logic         rty;
        logic [1:0]   err;
        logic [31:0]  adr;
        logic         ctag;
        logic [127:0] dat;
    } fta_cmd_response128_t;

endpackage

module scratchmem_arb2_fta
    import fta_bus_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int STARVE_LIM = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  fta_cmd_request128_t     req0,
    output fta_cmd_response128_t    resp0,
    input  fta_cmd_request128_t     req1,
    output fta_cmd_response128_t    resp1,
    output fta_cmd_request128_t     mreq,
    input  fta_cmd_response128_t    mresp,
    output logic [$clog2(DEPTH):0]  outstanding_o,
    output logic                    orphan_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIM);

    logic                 vld0, vld1;
    logic                 full, empty;
    logic                 starved0, starved1;
    logic                 pick1;
    logic                 acc0, acc1, accept;
    logic                 push, pop;
    logic                 last_grant_q;
    logic                 head_port;
    logic                 tid_bad;
    logic [CW-1:0]        starve0_q, starve1_q;
    logic [AW:0]          occ_q;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic                 port_mem [DEPTH];
    fta_cmd_request128_t  acc_req;
    fta_cmd_request128_t  mreq_q;
    fta_cmd_response128_t resp0_q, resp1_q;
    fta_cmd_response128_t ret_resp;
    logic                 orphan_q;

    // Arbitration: a starved port beats round-robin; a tie on starvation falls back to round-robin.
    always_comb begin
        vld0     = req0.cyc & req0.stb;
        vld1     = req1.cyc & req1.stb;
        full     = (occ_q == FULL_CNT);
        empty    = (occ_q == '0);
        starved0 = (starve0_q == STARVE_MAX);
        starved1 = (starve1_q == STARVE_MAX);
        pick1    = (starved0 != starved1) ? starved1 : ~last_grant_q;
        acc0     = 1'b0;
        acc1     = 1'b0;
        if (!full) begin
            if (vld0 && vld1) begin
                acc0 = ~pick1;
                acc1 = pick1;
            end else begin
                acc0 = vld0;
                acc1 = vld1;
            end
        end
        accept  = acc0 | acc1;
        acc_req = acc1 ? req1 : req0;
        push    = accept & (~acc_req.we | (acc_req.cti == ERC));
        pop     = mresp.ack & ~empty;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_grant_q <= 1'b1;
            starve0_q    <= '0;
            starve1_q    <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= acc1;
            end
            if (vld0 && !acc0) begin
                starve0_q <= starved0 ? starve0_q : starve0_q + 1'b1;
            end else begin
                starve0_q <= '0;
            end
            if (vld1 && !acc1) begin
                starve1_q <= starved1 ? starve1_q : starve1_q + 1'b1;
            end else begin
                starve1_q <= '0;
            end
        end
    end

    // Ownership FIFO: one entry per request that will be answered by an ack.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            port_mem[wr_ptr_q] <= acc1;
        end
    end

    assign head_port = port_mem[rd_ptr_q];

`ifdef SCRATCH_ARB_TIDCHK_EN
    logic [7:0] tid_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push) begin
            tid_mem[wr_ptr_q] <= acc_req.tid;
        end
    end

    assign tid_bad = (tid_mem[rd_ptr_q] != mresp.tid);
`else
    assign tid_bad = 1'b0;
`endif

    always_comb begin
        ret_resp       = mresp;
        ret_resp.ack   = 1'b1;
        ret_resp.stall = 1'b0;
        ret_resp.rty   = 1'b0;
        ret_resp.next  = 1'b0;
        if (tid_bad) begin
            ret_resp.err = DECERR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mreq_q <= '0;
        end else if (accept) begin
            mreq_q <= acc_req;
        end else begin
            mreq_q.cyc <= 1'b0;
            mreq_q.stb <= 1'b0;
        end
    end

    // Response steering: only the ack bit is cleared on idle cycles, other fields hold.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            resp0_q  <= '0;
            resp1_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            resp0_q.ack <= 1'b0;
            resp1_q.ack <= 1'b0;
            if (pop) begin
                if (head_port) begin
                    resp1_q <= ret_resp;
                end else begin
                    resp0_q <= ret_resp;
                end
            end
            if ((mresp.ack && empty) || (pop && tid_bad)) begin
                orphan_q <= 1'b1;
            end
        end
    end

    always_comb begin
        resp0       = resp0_q;
        resp0.stall = vld0 & ~acc0;
        resp1       = resp1_q;
        resp1.stall = vld1 & ~acc1;
    end

    assign mreq          = mreq_q;
    assign outstanding_o = occ_q;
    assign orphan_o      = orphan_q;

endmodule

// File: tb/tb_scratchmem_arb2_fta.sv
// tb/tb_scratchmem_arb2_fta.sv - randomized self-checking bench for scratchmem_arb2_fta against a queue-based model
module tb_scratchmem_arb2_fta;
    import fta_bus_pkg::*;

    localparam int DEPTH      = 16;
    localparam int STARVE_LIM = 8;
    localparam int OW         = $clog2(DEPTH) + 1;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    fta_cmd_request128_t  req0, req1, mreq;
    fta_cmd_response128_t resp0, resp1, mresp;
    logic [OW-1:0]        outstanding_o;
    logic                 orphan_o;

    always #5 clk_i = ~clk_i;

    scratchmem_arb2_fta #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req0          (req0),
        .resp0         (resp0),
        .req1          (req1),
        .resp1         (resp1),
        .mreq          (mreq),
        .mresp         (mresp),
        .outstanding_o (outstanding_o),
        .orphan_o      (orphan_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { int port; logic [7:0] tid; } own_t;
    typedef struct { logic [7:0] tid; int due; } sl_t;

    // Reference model state: ownership is simply a queue of (port, tid) in issue order.
    own_t                 own_q[$];
    int                   m_last;
    int                   m_starve [2];
    int                   m_pick = -1;
    bit                   m_orphan;
    fta_cmd_request128_t  m_mreq;
    fta_cmd_response128_t m_resp [2];

    fta_cmd_request128_t  pq0[$], pq1[$];
    sl_t                  sl_q[$];
    int                   cyc_n = 0;
    int                   sl_lat = 3;
    int                   sl_budget = 1 << 30;
    bit                   sl_rand = 0;
    bit                   sl_corrupt = 0;
    bit                   inj_ack = 0;
    logic [7:0]           inj_tid = '0;
    int                   ack_cnt [2];
    logic [1:0]           last_err [2];
    int                   peak = 0;
    bit                   logging = 0;
    logic [7:0]           mlog[$];
    int                   tid_ctr = 0;

    function automatic bit expecting(input fta_cmd_request128_t r);
        return !r.we || (r.cti == ERC);
    endfunction

    function automatic bit port_valid(input int p);
        return (p == 1) ? (req1.cyc && req1.stb) : (req0.cyc && req0.stb);
    endfunction

    function automatic fta_cmd_request128_t mk_req(input logic [7:0] tid, input logic we, input logic [2:0] cti);
        fta_cmd_request128_t r;
        r      = '0;
        r.cyc  = 1'b1;
        r.stb  = 1'b1;
        r.we   = we;
        r.cti  = cti;
        r.tid  = tid;
        r.asid = 8'($urandom);
        r.adr  = $urandom;
        r.sel  = 16'($urandom);
        r.dat  = {$urandom, $urandom, $urandom, $urandom};
        r.pri  = 4'($urandom);
        r.ctag = 1'($urandom);
        return r;
    endfunction

    function automatic fta_cmd_request128_t rand_req(input int p);
        logic [2:0] cti;
        logic [7:0] tid;
        case ($urandom_range(0, 2))
            0:       cti = ERC;
            1:       cti = INCR;
            default: cti = CLASSIC;
        endcase
        tid = {p[0], 7'(tid_ctr)};
        tid_ctr++;
        return mk_req(tid, 1'($urandom_range(0, 1)), cti);
    endfunction

    function automatic fta_cmd_response128_t slave_resp(input logic [7:0] tid);
        fta_cmd_response128_t r;
        r       = '0;
        r.ack   = 1'b1;
        r.tid   = tid;
        r.stall = 1'b1;
        r.next  = 1'b1;
        r.rty   = 1'b1;
        r.err   = tid[3] ? SLVERR : OKAY;
        r.asid  = tid ^ 8'h5A;
        r.adr   = {16'hA5A5, tid, 8'h00};
        r.pri   = tid[7:4];
        r.ctag  = tid[2];
        r.dat   = {4{32'(tid) * 32'h9E37_79B1}};
        return r;
    endfunction

    task automatic model_reset();
        own_q.delete();
        m_last      = 1;
        m_starve[0] = 0;
        m_starve[1] = 0;
        m_orphan    = 1'b0;
        m_mreq      = '0;
        m_resp[0]   = '0;
        m_resp[1]   = '0;
    endtask

    // Advance the model across the coming clock edge, using the inputs held during this cycle.
    task automatic model_update();
        fta_cmd_response128_t r;
        fta_cmd_request128_t  q;
        own_t                 o;
        if (!rst_i) begin
            model_reset();
            return;
        end
        m_resp[0].ack = 1'b0;
        m_resp[1].ack = 1'b0;
        if (mresp.ack) begin
            if (own_q.size() == 0) begin
                m_orphan = 1'b1;
            end else begin
                o       = own_q.pop_front();
                r       = mresp;
                r.ack   = 1'b1;
                r.stall = 1'b0;
                r.rty   = 1'b0;
                r.next  = 1'b0;
`ifdef SCRATCH_ARB_TIDCHK_EN
                if (o.tid != mresp.tid) begin
                    r.err    = DECERR;
                    m_orphan = 1'b1;
                end
`endif
                m_resp[o.port] = r;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (port_valid(p) && m_pick != p)
                m_starve[p] = (m_starve[p] < STARVE_LIM) ? m_starve[p] + 1 : STARVE_LIM;
            else
                m_starve[p] = 0;
        end
        if (m_pick >= 0) begin
            q      = (m_pick == 1) ? req1 : req0;
            m_mreq = q;
            if (expecting(q)) begin
                o.port = m_pick;
                o.tid  = q.tid;
                own_q.push_back(o);
            end
            m_last = m_pick;
            if (m_pick == 0 && pq0.size() > 0) pq0.delete(0);
            if (m_pick == 1 && pq1.size() > 0) pq1.delete(0);
        end else begin
            m_mreq.cyc = 1'b0;
            m_mreq.stb = 1'b0;
        end
    endtask

    task automatic eval();
        fta_cmd_response128_t e;
        sl_t s;
        bit  v0, v1, s0, s1;
        v0     = port_valid(0);
        v1     = port_valid(1);
        m_pick = -1;
        if (own_q.size() < DEPTH) begin
            if (v0 && v1) begin
                s0 = (m_starve[0] == STARVE_LIM);
                s1 = (m_starve[1] == STARVE_LIM);
                if (s0 && !s1)      m_pick = 0;
                else if (s1 && !s0) m_pick = 1;
                else                m_pick = 1 - m_last;
            end else if (v0) begin
                m_pick = 0;
            end else if (v1) begin
                m_pick = 1;
            end
        end
        check("mreq", 256'(mreq), 256'(m_mreq));
        e       = m_resp[0];
        e.stall = v0 && (m_pick != 0);
        check("resp0", 256'(resp0), 256'(e));
        e       = m_resp[1];
        e.stall = v1 && (m_pick != 1);
        check("resp1", 256'(resp1), 256'(e));
        check("outstanding", 256'(outstanding_o), 256'(own_q.size()));
        check("orphan", 256'(orphan_o), 256'(m_orphan));
        if (resp0.ack) begin ack_cnt[0]++; last_err[0] = resp0.err; end
        if (resp1.ack) begin ack_cnt[1]++; last_err[1] = resp1.err; end
        if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
        if (mreq.cyc && mreq.stb) begin
            if (logging) mlog.push_back(mreq.tid);
            if (expecting(mreq)) begin
                s.tid = mreq.tid;
                s.due = cyc_n + (sl_rand ? int'($urandom_range(1, 4)) : sl_lat);
                sl_q.push_back(s);
            end
        end
    endtask

    task automatic step();
        sl_t s;
        model_update();
        @(posedge clk_i);
        #1;
        cyc_n++;
        req0  = (pq0.size() > 0) ? pq0[0] : '0;
        req1  = (pq1.size() > 0) ? pq1[0] : '0;
        mresp = '0;
        if (inj_ack) begin
            mresp.ack = 1'b1;
            mresp.tid = inj_tid;
            inj_ack   = 1'b0;
        end else if (rst_i && sl_q.size() > 0 && sl_q[0].due <= cyc_n && sl_budget > 0 &&
                     (!sl_rand || $urandom_range(0, 3) != 0)) begin
            s = sl_q.pop_front();
            sl_budget--;
            mresp      = slave_resp(sl_corrupt ? (s.tid ^ 8'h01) : s.tid);
            sl_corrupt = 1'b0;
        end
        @(negedge clk_i);
        eval();
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || sl_q.size() > 0 || own_q.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        check("idle_within_budget", 256'(n < maxc), 256'(1));
        repeat (3) step();
    endtask

    initial begin
        int b0, b1;
        logic [7:0] g;
        rst_i = 1'b0;
        req0  = '0;
        req1  = '0;
        mresp = '0;
        model_reset();

        repeat (3) step();
        rst_i = 1'b1;
        step();
        check("reset_mreq_cyc", 256'(mreq.cyc), 256'(0));
        check("reset_resp0_ack", 256'(resp0.ack), 256'(0));
        check("reset_resp1_ack", 256'(resp1.ack), 256'(0));
        check("reset_outstanding", 256'(outstanding_o), 256'(0));
        check("reset_orphan", 256'(orphan_o), 256'(0));

        // Both ports streaming reads: strict alternation starting with port 0.
        for (int i = 0; i < 8; i++) begin
            pq0.push_back(mk_req(8'h10 + 8'(i), 1'b0, CLASSIC));
            pq1.push_back(mk_req(8'h20 + 8'(i), 1'b0, CLASSIC));
        end
        b0 = ack_cnt[0];
        b1 = ack_cnt[1];
        mlog.delete();
        logging = 1'b1;
        run_until_idle(200);
        logging = 1'b0;
        check("alt_count", 256'(mlog.size()), 256'(16));
        for (int i = 0; i < 16; i++) begin
            g = (i < mlog.size()) ? mlog[i] : 8'hxx;
            check("alt_order", 256'(g), 256'(((i % 2) ? 8'h20 : 8'h10) + 8'(i / 2)));
        end
        check("alt_acks0", 256'(ack_cnt[0] - b0), 256'(8));
        check("alt_acks1", 256'(ack_cnt[1] - b1), 256'(8));

        // Non-ERC write is untracked; ERC write and read are.
        b0   = ack_cnt[0];
        peak = 0;
        pq0.push_back(mk_req(8'h30, 1'b1, CLASSIC));
        pq0.push_back(mk_req(8'h31, 1'b1, ERC));
        pq0.push_back(mk_req(8'h32, 1'b0, CLASSIC));
        run_until_idle(100);
        check("erc_peak", 256'(peak), 256'(2));
        check("erc_acks0", 256'(ack_cnt[0] - b0), 256'(2));

        // Fill the FIFO with acks withheld, then release one ack.
        sl_budget = 0;
        for (int i = 0; i < 17; i++) pq1.push_back(mk_req(8'h40 + 8'(i), 1'b0, CLASSIC));
        for (int i = 0; i < 60 && pq1.size() > 1; i++) step();
        repeat (STARVE_LIM + 2) step();
        check("full_occ", 256'(outstanding_o), 256'(DEPTH));
        check("full_stall1", 256'(resp1.stall), 256'(1));
        pq0.push_back(mk_req(8'h60, 1'b0, CLASSIC));
        step();
        sl_budget = 1;
        step();
        check("stall_until_pop", 256'(resp1.stall), 256'(1));
        step();
        check("release_stall1", 256'(resp1.stall), 256'(0));
        check("forced_prio_stall0", 256'(resp0.stall), 256'(1));
        sl_budget = 1 << 30;
        step();
        check("forced_prio_mreq", 256'(mreq.tid), 256'(8'h50));
        run_until_idle(200);

        // Ack on an idle bus.
        b0      = ack_cnt[0];
        b1      = ack_cnt[1];
        inj_tid = 8'h77;
        inj_ack = 1'b1;
        step();
        step();
        check("orphan_set", 256'(orphan_o), 256'(1));
        check("orphan_no_ack", 256'(ack_cnt[0] + ack_cnt[1] - b0 - b1), 256'(0));
        repeat (5) step();
        check("orphan_sticky", 256'(orphan_o), 256'(1));
        rst_i = 1'b0;
        repeat (2) step();
        rst_i = 1'b1;
        step();
        check("orphan_cleared", 256'(orphan_o), 256'(0));

`ifdef SCRATCH_ARB_TIDCHK_EN
        pq0.push_back(mk_req(8'h04, 1'b0, CLASSIC));
        sl_corrupt = 1'b1;
        b0 = ack_cnt[0];
        run_until_idle(50);
        check("tidchk_ack", 256'(ack_cnt[0] - b0), 256'(1));
        check("tidchk_err", 256'(last_err[0]), 256'(DECERR));
        check("tidchk_orphan", 256'(orphan_o), 256'(1));
        rst_i = 1'b0;
        repeat (2) step();
        rst_i = 1'b1;
        step();
`endif

        // Random traffic with periodic ack hold-offs to reach full and starvation.
        sl_rand = 1'b1;
        for (int c = 0; c < 640; c++) begin
            if (c % 80 == 0)  sl_budget = 0;
            if (c % 80 == 40) sl_budget = 1 << 30;
            if (pq0.size() < 3 && $urandom_range(0, 1) == 0) pq0.push_back(rand_req(0));
            if (pq1.size() < 3 && $urandom_range(0, 1) == 0) pq1.push_back(rand_req(1));
            step();
        end
        sl_budget = 1 << 30;
        run_until_idle(400);
        sl_rand = 1'b0;

        // Reset with requests in flight: their acks must come back as orphans.
        sl_budget = 0;
        for (int i = 0; i < 4; i++) pq0.push_back(mk_req(8'h70 + 8'(i), 1'b0, CLASSIC));
        repeat (8) step();
        check("pre_reset_occ", 256'(outstanding_o), 256'(4));
        rst_i = 1'b0;
        repeat (2) step();
        rst_i     = 1'b1;
        sl_budget = 1 << 30;
        run_until_idle(50);
        check("reset_midop_orphan", 256'(orphan_o), 256'(1));
        check("reset_midop_occ", 256'(outstanding_o), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
